// File: rtl/stq_alloc_ctrl_a.sv
// stq_alloc_ctrl_a: store-queue alloc/retire/drain pointer control with flush rollback
module stq_alloc_ctrl_a #(
    parameter int BUF_COUNT = 64,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallA,
    input  logic                 excpt,
    input  logic [1:0]           alloc_cnt,
    output logic                 alloc_gnt,
    output logic [IDX_W-1:0]     alloc0_idx,
    output logic [IDX_W-1:0]     alloc1_idx,
    output logic [BUF_COUNT-1:0] wrt0_en,
    output logic [BUF_COUNT-1:0] wrt1_en,
    input  logic [1:0]           retire_cnt,
    output logic [BUF_COUNT-1:0] passe_en,
    output logic                 drain_valid,
    output logic [IDX_W-1:0]     drain_idx,
    input  logic                 drain_ack,
    output logic [BUF_COUNT-1:0] free_en,
    output logic [IDX_W:0]       count,
    output logic                 full,
    output logic                 empty
);
    localparam int PW = IDX_W + 1;
    localparam logic [BUF_COUNT-1:0] ONE = BUF_COUNT'(1);
    logic [PW-1:0] alloc_ptr, retire_ptr, drain_ptr, unret, free_slots, rnew, fl_len;
    logic [IDX_W-1:0] d;
    logic [1:0] areq, rreq, eff;
    logic drain_fire;
    always_comb begin
        areq = (alloc_cnt == 2'd3) ? 2'd0 : alloc_cnt;
        rreq = (retire_cnt == 2'd3) ? 2'd0 : retire_cnt;
        count = alloc_ptr - drain_ptr;
        free_slots = PW'(BUF_COUNT) - count;
        full = count == PW'(BUF_COUNT);
        empty = count == '0;
        unret = alloc_ptr - retire_ptr;
        eff = (unret < PW'(rreq)) ? unret[1:0] : rreq;
        rnew = retire_ptr + PW'(eff);
        fl_len = alloc_ptr - rnew;
        alloc_gnt = (areq != 2'd0) && !stallA && !excpt && (free_slots >= PW'(areq));
        alloc0_idx = alloc_ptr[IDX_W-1:0];
        alloc1_idx = alloc0_idx + IDX_W'(1);
        wrt0_en = alloc_gnt ? ONE << alloc0_idx : '0;
        wrt1_en = (alloc_gnt && areq == 2'd2) ? ONE << alloc1_idx : '0;
        passe_en = ((eff != 2'd0) ? ONE << retire_ptr[IDX_W-1:0] : '0)
                 | ((eff == 2'd2) ? ONE << (retire_ptr[IDX_W-1:0] + IDX_W'(1)) : '0);
        drain_valid = retire_ptr != drain_ptr;
        drain_idx = drain_ptr[IDX_W-1:0];
        drain_fire = drain_valid && drain_ack;
        free_en = drain_fire ? ONE << drain_idx : '0;
        d = '0;
        // flush frees every slot whose distance from the post-retire pointer is below the unretired length
        for (int i = 0; i < BUF_COUNT; i++) begin
            d = IDX_W'(i) - rnew[IDX_W-1:0];
            if (excpt && PW'(d) < fl_len) free_en[i] = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr  <= '0;
            retire_ptr <= '0;
            drain_ptr  <= '0;
        end else begin
            alloc_ptr  <= excpt ? rnew : alloc_ptr + (alloc_gnt ? PW'(areq) : PW'(0));
            retire_ptr <= rnew;
            drain_ptr  <= drain_ptr + PW'(drain_fire);
        end
    end
endmodule
